// File: rtl/sdram_read_if.sv
// sdram_read_if: trigger/grant handshake, SDRAM command bus and read-data
// return between the read engine (slave) and the controller (master).
`timescale 1ns/1ps
interface sdram_read_if;
  logic        rd_trig;
  logic        rd_en;
  logic        aref_req;
  logic [15:0] sdram_dq_in;
  logic        rd_req;
  logic        rd_end;
  logic        rd_busy;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic [15:0] rd_data;
  logic        rd_data_vld;

  modport slave (
    input  rd_trig, rd_en, aref_req, sdram_dq_in,
    output rd_req, rd_end, rd_busy, rd_cmd, rd_addr, rd_bank, rd_data, rd_data_vld
  );

  modport master (
    output rd_trig, rd_en, aref_req, sdram_dq_in,
    input  rd_req, rd_end, rd_busy, rd_cmd, rd_addr, rd_bank, rd_data, rd_data_vld
  );
endinterface

// File: rtl/sdram_read.sv
// sdram_read: read-burst engine. Requests the bus, opens ROW_ADDR, issues
// gapless 4-word READ bursts, captures data after CAS latency, precharges and
// releases the bus. A pending refresh ends the run early at a burst boundary;
// the engine then re-requests and resumes at the saved column.
`timescale 1ns/1ps
module sdram_read #(
  parameter int unsigned CAS_LAT   = 3,
  parameter int unsigned BURST_NUM = 4,
  parameter logic [11:0] ROW_ADDR  = 12'd0,
  parameter logic [1:0]  BANK      = 2'd0
) (
  input logic         sclk,
  input logic         s_rst,
  sdram_read_if.slave bus
);

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdRead = 4'b0101;
  localparam logic [3:0] CmdPre  = 4'b0010;
  // One bit wider than the 9-bit column so BURST_NUM=128 (512 cols) is representable.
  localparam logic [9:0] TotalCols = 10'(BURST_NUM * 4);

  typedef enum logic [2:0] {StIdle, StReq, StAct, StRead, StPre, StEnd} state_e;

  state_e             r_state, w_state_nxt;
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic [9:0]         r_col;
  logic               w_col_clr, w_rd_issue, w_done;
  logic               w_req, w_end;
  logic [3:0]         w_cmd;
  logic [11:0]        w_addr;
  logic [1:0]         w_bank;
  logic [CAS_LAT-1:0] r_pipe;
  logic [1:0]         r_cap_cnt;
  logic               w_cap;
  logic [15:0]        r_data;
  logic               r_data_vld;

  // r_col counts issued READs (x4), so it equals TotalCols once the last one is out.
  assign w_done = (r_col == TotalCols);

  // State, phase counter and column register.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_col_clr) begin
        r_col <= '0;
      end else if (w_rd_issue) begin
        r_col <= r_col + 10'd4;
      end
    end
  end

  // Next state and command bus; the bus defaults to NOP with zero address.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_col_clr   = 1'b0;
    w_rd_issue  = 1'b0;
    w_req       = 1'b0;
    w_end       = 1'b0;
    w_cmd       = CmdNop;
    w_addr      = '0;
    w_bank      = '0;
    case (r_state)
      StIdle: begin
        if (bus.rd_trig) begin
          w_state_nxt = StReq;
          w_col_clr   = 1'b1;
        end
      end
      StReq: begin
        w_req = 1'b1;
        if (bus.rd_en) w_state_nxt = StAct;
      end
      StAct: begin
        w_req  = 1'b1;
        w_addr = ROW_ADDR;
        w_bank = BANK;
        if (r_cnt == 2'd0) w_cmd = CmdAct;
        if (r_cnt == 2'd2) w_state_nxt = StRead;
        else               w_cnt_nxt   = r_cnt + 2'd1;
      end
      StRead: begin
        w_req  = 1'b1;
        w_addr = {3'b000, r_col[8:0]};
        w_bank = BANK;
        if (r_cnt == 2'd0) begin
          w_cmd      = CmdRead;
          w_rd_issue = 1'b1;
        end
        // Burst boundary: stop on completion or pending refresh, else wrap to next READ.
        if (r_cnt == 2'd3) begin
          if (w_done || bus.aref_req) w_state_nxt = StPre;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      StPre: begin
        w_req       = 1'b1;
        w_cmd       = CmdPre;
        w_addr      = 12'h400;
        w_bank      = BANK;
        w_state_nxt = StEnd;
      end
      StEnd: begin
        if (r_cnt == 2'd2) begin
          w_end       = 1'b1;
          w_state_nxt = w_done ? StIdle : StReq;
        end else begin
          w_req     = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Delay each READ through CAS latency, then hold a 4-word capture window.
  assign w_cap = r_pipe[CAS_LAT-1] | (r_cap_cnt != 2'd0);

  // Read-data capture pipeline.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_pipe     <= '0;
      r_cap_cnt  <= '0;
      r_data     <= '0;
      r_data_vld <= 1'b0;
    end else begin
      r_pipe[0] <= w_rd_issue;
      for (int i = 1; i < int'(CAS_LAT); i++) r_pipe[i] <= r_pipe[i-1];
      if (r_pipe[CAS_LAT-1])     r_cap_cnt <= 2'd3;
      else if (r_cap_cnt != 2'd0) r_cap_cnt <= r_cap_cnt - 2'd1;
      if (w_cap) r_data <= bus.sdram_dq_in;
      r_data_vld <= w_cap;
    end
  end

  assign bus.rd_req      = w_req;
  assign bus.rd_end      = w_end;
  assign bus.rd_busy     = (r_state != StIdle);
  assign bus.rd_cmd      = w_cmd;
  assign bus.rd_addr     = w_addr;
  assign bus.rd_bank     = w_bank;
  assign bus.rd_data     = r_data;
  assign bus.rd_data_vld = r_data_vld;

endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: directed bench for sdram_read. A small SDRAM model returns
// 16'h0100+col for each READ after CAS latency; a negedge monitor logs
// commands, rd_end and valid words, and each test checks the log against
// hand-computed cycle offsets from its trigger.
`timescale 1ns/1ps
module tb_sdram_read;
  localparam int         CL      = 3;
  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdRead = 4'b0101;
  localparam logic [3:0] CmdPre  = 4'b0010;

  logic sclk = 1'b0;
  logic s_rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  sdram_read_if u_if ();
  sdram_read_if u_if1 ();

  sdram_read #(.CAS_LAT(CL), .BURST_NUM(4), .ROW_ADDR(12'd0), .BANK(2'd0)) u_dut (
    .sclk (sclk),
    .s_rst(s_rst),
    .bus  (u_if.slave)
  );

  sdram_read #(.CAS_LAT(CL), .BURST_NUM(1), .ROW_ADDR(12'h05A), .BANK(2'd2)) u_dut1 (
    .sclk (sclk),
    .s_rst(s_rst),
    .bus  (u_if1.slave)
  );

  // Main-instance logs.
  int act_q[$], rd_cyc_q[$], rd_addr_q[$], pre_q[$], pre_a10_q[$], end_q[$];
  int vld_cyc_q[$], vld_dat_q[$], busy_rise_q[$];
  int busy_last;
  bit prev_busy;
  bit [16:0] slot [32];
  bit [16:0] slot_w;
  // BURST_NUM=1 instance logs.
  int b_act_q[$], b_act_ab_q[$], b_rd_q[$], b_rd_ab_q[$], b_pre_q[$], b_pre_ab_q[$];
  int b_end_q[$], b_vld_cyc_q[$], b_vld_dat_q[$];

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // SDRAM model and monitor for the main instance.
  always @(negedge sclk) begin
    if (u_if.rd_cmd == CmdRead) begin
      for (int i = 0; i < 4; i++)
        slot[5'((cyc + CL + i) % 32)] = {1'b1, 16'h0100 + {7'd0, u_if.rd_addr[8:0]} + 16'(i)};
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(int'(u_if.rd_addr));
    end
    if (u_if.rd_cmd == CmdAct) act_q.push_back(cyc);
    if (u_if.rd_cmd == CmdPre) begin
      pre_q.push_back(cyc);
      pre_a10_q.push_back(int'(u_if.rd_addr[10]));
    end
    if (u_if.rd_end) end_q.push_back(cyc);
    if (u_if.rd_data_vld) begin
      vld_cyc_q.push_back(cyc);
      vld_dat_q.push_back(int'(u_if.rd_data));
    end
    if (u_if.rd_busy && !prev_busy) busy_rise_q.push_back(cyc);
    if (u_if.rd_busy) busy_last = cyc;
    prev_busy = u_if.rd_busy;
    slot_w = slot[5'(cyc % 32)];
    slot[5'(cyc % 32)] = '0;
    u_if.sdram_dq_in = slot_w[16] ? slot_w[15:0] : 16'hDEAD;
  end

  // Monitor for the BURST_NUM=1 instance; its DQ carries 16'h0200+cycle.
  always @(negedge sclk) begin
    u_if1.sdram_dq_in = 16'h0200 + 16'(cyc);
    if (u_if1.rd_cmd == CmdAct) begin
      b_act_q.push_back(cyc);
      b_act_ab_q.push_back(int'({u_if1.rd_bank, u_if1.rd_addr}));
    end
    if (u_if1.rd_cmd == CmdRead) begin
      b_rd_q.push_back(cyc);
      b_rd_ab_q.push_back(int'({u_if1.rd_bank, u_if1.rd_addr}));
    end
    if (u_if1.rd_cmd == CmdPre) begin
      b_pre_q.push_back(cyc);
      b_pre_ab_q.push_back(int'({u_if1.rd_bank, u_if1.rd_addr}));
    end
    if (u_if1.rd_end) b_end_q.push_back(cyc);
    if (u_if1.rd_data_vld) begin
      b_vld_cyc_q.push_back(cyc);
      b_vld_dat_q.push_back(int'(u_if1.rd_data));
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_log();
    act_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete(); pre_q.delete();
    pre_a10_q.delete(); end_q.delete(); vld_cyc_q.delete(); vld_dat_q.delete();
    busy_rise_q.delete();
  endtask

  task automatic chk_data(input string tag);
    chk_eq({tag, "_vld_n"}, vld_cyc_q.size(), 16);
    for (int k = 0; k < 16; k++) chk_eq({tag, "_data"}, qget(vld_dat_q, k), 'h100 + k);
  endtask

  // Trigger, grant one cycle after rd_req, optional stray trigger at t0+extra.
  task automatic run_basic(input int extra, output int t0);
    clear_log();
    tick();
    t0 = cyc;
    u_if.rd_trig = 1'b1;
    tick();
    u_if.rd_trig = 1'b0;
    @(negedge sclk);
    chk_eq("req_up", int'(u_if.rd_req), 1);
    tick();
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    while (cyc < t0 + 30) begin
      u_if.rd_trig = (cyc == t0 + extra);
      tick();
    end
    u_if.rd_trig = 1'b0;
  endtask

  task automatic check_basic(input string tag, input int t0);
    chk_eq({tag, "_act_n"}, act_q.size(), 1);
    chk_eq({tag, "_act_cyc"}, qget(act_q, 0), t0 + 3);
    chk_eq({tag, "_rd_n"}, rd_cyc_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk_eq({tag, "_rd_cyc"}, qget(rd_cyc_q, k), t0 + 6 + 4 * k);
      chk_eq({tag, "_rd_addr"}, qget(rd_addr_q, k), 4 * k);
    end
    chk_eq({tag, "_pre_n"}, pre_q.size(), 1);
    chk_eq({tag, "_pre_cyc"}, qget(pre_q, 0), t0 + 22);
    chk_eq({tag, "_pre_a10"}, qget(pre_a10_q, 0), 1);
    chk_eq({tag, "_end_n"}, end_q.size(), 1);
    chk_eq({tag, "_end_cyc"}, qget(end_q, 0), t0 + 25);
    chk_eq({tag, "_busy_rise"}, qget(busy_rise_q, 0), t0 + 1);
    chk_eq({tag, "_busy_last"}, busy_last, t0 + 25);
    chk_eq({tag, "_vld_first"}, qget(vld_cyc_q, 0), t0 + 10);
    chk_eq({tag, "_vld_last"}, qget(vld_cyc_q, 15), t0 + 25);
    chk_data(tag);
  endtask

  task automatic test_aref();
    int t0;
    int rd_off[4]  = '{6, 10, 23, 27};
    int pre_off[2] = '{14, 31};
    int end_off[2] = '{17, 34};
    clear_log();
    tick();
    t0 = cyc;
    u_if.rd_trig = 1'b1;
    tick();
    u_if.rd_trig = 1'b0;
    tick();
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    wait_to(t0 + 12);
    u_if.aref_req = 1'b1;
    wait_to(t0 + 17);
    @(negedge sclk);
    chk_eq("aref_req_drop", int'(u_if.rd_req), 0);
    tick();
    u_if.aref_req = 1'b0;
    @(negedge sclk);
    chk_eq("aref_req_again", int'(u_if.rd_req), 1);
    tick();
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    wait_to(t0 + 45);
    chk_eq("aref_act_n", act_q.size(), 2);
    chk_eq("aref_act0", qget(act_q, 0), t0 + 3);
    chk_eq("aref_act1", qget(act_q, 1), t0 + 20);
    chk_eq("aref_rd_n", rd_cyc_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk_eq("aref_rd_cyc", qget(rd_cyc_q, k), t0 + rd_off[k]);
      chk_eq("aref_rd_addr", qget(rd_addr_q, k), 4 * k);
    end
    for (int k = 0; k < 2; k++) begin
      chk_eq("aref_pre_cyc", qget(pre_q, k), t0 + pre_off[k]);
      chk_eq("aref_end_cyc", qget(end_q, k), t0 + end_off[k]);
    end
    chk_eq("aref_end_n", end_q.size(), 2);
    chk_eq("aref_vld_w7", qget(vld_cyc_q, 7), t0 + 17);
    chk_eq("aref_vld_w8", qget(vld_cyc_q, 8), t0 + 27);
    chk_eq("aref_vld_w15", qget(vld_cyc_q, 15), t0 + 34);
    chk_eq("aref_busy_last", busy_last, t0 + 34);
    chk_data("aref");
  endtask

  task automatic test_grant_wait();
    int t0;
    int bad;
    clear_log();
    tick();
    t0 = cyc;
    u_if.rd_trig = 1'b1;
    tick();
    u_if.rd_trig = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge sclk);
      if (u_if.rd_cmd != CmdNop || u_if.rd_req != 1'b1) bad++;
    end
    chk_eq("wait_bad_cycles", bad, 0);
    tick();
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    wait_to(t0 + 80);
    chk_eq("wait_act_cyc", qget(act_q, 0), t0 + 52);
    chk_eq("wait_end_cyc", qget(end_q, 0), t0 + 74);
    chk_data("wait");
  endtask

  task automatic test_reset();
    int t0;
    int t1;
    clear_log();
    tick();
    t0 = cyc;
    u_if.rd_trig = 1'b1;
    tick();
    u_if.rd_trig = 1'b0;
    tick();
    u_if.rd_en = 1'b1;
    tick();
    u_if.rd_en = 1'b0;
    wait_to(t0 + 15);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    @(negedge sclk);
    chk_eq("rst_rd_n_before", rd_cyc_q.size(), 3);
    chk_eq("rst_req", int'(u_if.rd_req), 0);
    chk_eq("rst_end", int'(u_if.rd_end), 0);
    chk_eq("rst_busy", int'(u_if.rd_busy), 0);
    chk_eq("rst_vld", int'(u_if.rd_data_vld), 0);
    chk_eq("rst_cmd", int'(u_if.rd_cmd), int'(CmdNop));
    chk_eq("rst_addr", int'(u_if.rd_addr), 0);
    chk_eq("rst_data", int'(u_if.rd_data), 0);
    wait_to(t0 + 24);
    run_basic(-100, t1);
    check_basic("rst_rerun", t1);
  endtask

  task automatic test_burst1();
    int t0;
    tick();
    t0 = cyc;
    u_if1.rd_trig = 1'b1;
    tick();
    u_if1.rd_trig = 1'b0;
    tick();
    u_if1.rd_en = 1'b1;
    tick();
    u_if1.rd_en = 1'b0;
    wait_to(t0 + 20);
    chk_eq("b1_act_cyc", qget(b_act_q, 0), t0 + 3);
    chk_eq("b1_act_bank_row", qget(b_act_ab_q, 0), 'h205A);
    chk_eq("b1_rd_n", b_rd_q.size(), 1);
    chk_eq("b1_rd_cyc", qget(b_rd_q, 0), t0 + 6);
    chk_eq("b1_rd_bank_col", qget(b_rd_ab_q, 0), 'h2000);
    chk_eq("b1_pre_cyc", qget(b_pre_q, 0), t0 + 10);
    chk_eq("b1_pre_bank_a10", qget(b_pre_ab_q, 0), 'h2400);
    chk_eq("b1_end_cyc", qget(b_end_q, 0), t0 + 13);
    chk_eq("b1_vld_n", b_vld_cyc_q.size(), 4);
    chk_eq("b1_vld_first", qget(b_vld_cyc_q, 0), t0 + 10);
    for (int k = 0; k < 4; k++) chk_eq("b1_data", qget(b_vld_dat_q, k), 'h200 + t0 + 9 + k);
  endtask

  initial begin
    int t0;
    s_rst = 1'b1;
    u_if.rd_trig = 1'b0;  u_if.rd_en = 1'b0;  u_if.aref_req = 1'b0;
    u_if1.rd_trig = 1'b0; u_if1.rd_en = 1'b0; u_if1.aref_req = 1'b0;
    repeat (3) tick();
    s_rst = 1'b0;
    tick();
    @(negedge sclk);
    chk_eq("reset_cmd", int'(u_if.rd_cmd), int'(CmdNop));
    chk_eq("reset_req", int'(u_if.rd_req), 0);
    chk_eq("reset_busy", int'(u_if.rd_busy), 0);
    chk_eq("reset_end", int'(u_if.rd_end), 0);
    chk_eq("reset_vld", int'(u_if.rd_data_vld), 0);
    chk_eq("reset_addr_bank", int'({u_if.rd_bank, u_if.rd_addr}), 0);
    chk_eq("reset_data", int'(u_if.rd_data), 0);
    chk_eq("reset_b1_cmd", int'(u_if1.rd_cmd), int'(CmdNop));

    run_basic(-100, t0);
    check_basic("basic", t0);

    test_aref();

    run_basic(8, t0);
    check_basic("retrig", t0);
    wait_to(t0 + 40);
    chk_eq("retrig_act_n_late", act_q.size(), 1);
    chk_eq("retrig_busy_late", int'(u_if.rd_busy), 0);

    test_grant_wait();
    test_reset();
    test_burst1();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
